multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit_if.sv | 33 +++
 rtl/multicycle_control_unit.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit (master) and the datapath (slave).
// It carries the instruction fields, the ALU flags, the memory handshake and all select/enable lines.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       zero_flag;
    logic       lt_flag;
    logic       ltu_flag;
    logic       mem_ready;
    logic       sel_bit;
    logic       mux1_load_bit;
    logic       mem_read;
    logic       mem_write_en;
    logic       reg_write_en;
    logic       write_mux_sel;
    logic [1:0] sel_bit_PC;
    logic       pc_write;
    logic       ir_write;
    logic       trap;
    logic [2:0] state;

    modport master (
        input  opcode, func3, zero_flag, lt_flag, ltu_flag, mem_ready,
        output sel_bit, mux1_load_bit, mem_read, mem_write_en, reg_write_en,
               write_mux_sel, sel_bit_PC, pc_write, ir_write, trap, state
    );

    modport slave (
        output opcode, func3, zero_flag, lt_flag, ltu_flag, mem_ready,
        input  sel_bit, mux1_load_bit, mem_read, mem_write_en, reg_write_en,
               write_mux_sel, sel_bit_PC, pc_write, ir_write, trap, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a timed
// memory handshake and a sticky TRAP state. Only the state and the wait counter are registered.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT   = 16,
    parameter bit EN_EXT_BRANCH = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] cnt_inc;

    logic is_r, is_i, is_lw, is_sw, is_b, is_jal, is_jalr;
    logic br_legal, legal, taken;

    logic       sel_bit, mux1_load_bit, mem_read, mem_write_en, reg_write_en;
    logic       write_mux_sel, pc_write, ir_write, trap;
    logic [1:0] sel_bit_PC;

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        is_r    = (bus.opcode == 7'b0110011);
        is_i    = (bus.opcode == 7'b0010011);
        is_lw   = (bus.opcode == 7'b0000011);
        is_sw   = (bus.opcode == 7'b0100011);
        is_b    = (bus.opcode == 7'b1100011);
        is_jal  = (bus.opcode == 7'b1101111);
        is_jalr = (bus.opcode == 7'b1100111);
        // func3 010/011 are never branches; 1xx only when the extended set is enabled
        br_legal = (bus.func3[2:1] == 2'b00) || (bus.func3[2] && EN_EXT_BRANCH);
        legal    = is_r || is_i || is_lw || is_sw || (is_b && br_legal) || is_jal || is_jalr;
        case (bus.func3)
            3'b000:  taken = bus.zero_flag;
            3'b001:  taken = !bus.zero_flag;
            3'b100:  taken = bus.lt_flag;
            3'b101:  taken = !bus.lt_flag;
            3'b110:  taken = bus.ltu_flag;
            3'b111:  taken = !bus.ltu_flag;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_bit       = 1'b0;
        mux1_load_bit = 1'b0;
        mem_read      = 1'b0;
        mem_write_en  = 1'b0;
        reg_write_en  = 1'b0;
        write_mux_sel = 1'b0;
        sel_bit_PC    = 2'b00;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        trap          = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_r) begin
                    state_d = S_WB;
                end else if (is_i) begin
                    sel_bit = 1'b1;
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    sel_bit       = 1'b1;
                    mux1_load_bit = 1'b1;
                    cnt_d         = 8'd0;
                    state_d       = S_MEM;
                end else if (is_b) begin
                    pc_write   = 1'b1;
                    sel_bit_PC = taken ? 2'b10 : 2'b00;
                    state_d    = S_FETCH;
                end else if (is_jal) begin
                    reg_write_en = 1'b1;
                    pc_write     = 1'b1;
                    sel_bit_PC   = 2'b01;
                    state_d      = S_FETCH;
                end else if (is_jalr) begin
                    sel_bit      = 1'b1;
                    reg_write_en = 1'b1;
                    pc_write     = 1'b1;
                    sel_bit_PC   = 2'b11;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                sel_bit       = 1'b1;
                mux1_load_bit = 1'b1;
                mem_read      = is_lw;
                mem_write_en  = is_sw;
                // a ready in the timeout cycle still completes the access
                if (bus.mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_inc[7:0];
                    if (cnt_inc >= 9'(MEM_TIMEOUT)) begin
                        state_d = S_TRAP;
                    end
                end
            end
            S_WB: begin
                reg_write_en  = 1'b1;
                write_mux_sel = 1'b1;
                pc_write      = 1'b1;
                mem_read      = is_lw;
                mux1_load_bit = is_lw;
                state_d       = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // reset drops every request combinationally, including a pending memory access
        if (!rst_n) begin
            sel_bit       = 1'b0;
            mux1_load_bit = 1'b0;
            mem_read      = 1'b0;
            mem_write_en  = 1'b0;
            reg_write_en  = 1'b0;
            write_mux_sel = 1'b0;
            sel_bit_PC    = 2'b00;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            trap          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel_bit       = sel_bit;
    assign bus.mux1_load_bit = mux1_load_bit;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write_en  = mem_write_en;
    assign bus.reg_write_en  = reg_write_en;
    assign bus.write_mux_sel = write_mux_sel;
    assign bus.sel_bit_PC    = sel_bit_PC;
    assign bus.pc_write      = pc_write;
    assign bus.ir_write      = ir_write;
    assign bus.trap          = trap;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded into its expected
// phase sequence from latency rules, and outputs are compared every cycle.
module tb_multicycle_control_unit;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_MW = 3, P_MD = 4, P_W = 5, P_T = 6;
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_B = 4, C_JAL = 5, C_JALR = 6, C_ILL = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opc = 7'd0;
    logic [2:0] f3r = 3'd0;
    logic       zf = 1'b0, lf = 1'b0, uf = 1'b0, rdy = 1'b0;
    int         sel = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if bus_a();
    multicycle_control_unit_if bus_b();

    assign bus_a.opcode = opc;     assign bus_b.opcode = opc;
    assign bus_a.func3 = f3r;      assign bus_b.func3 = f3r;
    assign bus_a.zero_flag = zf;   assign bus_b.zero_flag = zf;
    assign bus_a.lt_flag = lf;     assign bus_b.lt_flag = lf;
    assign bus_a.ltu_flag = uf;    assign bus_b.ltu_flag = uf;
    assign bus_a.mem_ready = rdy;  assign bus_b.mem_ready = rdy;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .EN_EXT_BRANCH(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    multicycle_control_unit #(.MEM_TIMEOUT(16), .EN_EXT_BRANCH(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    // {trap, ir_write, pc_write, sel_bit_PC, write_mux_sel, reg_write_en, mem_write_en, mem_read, mux1_load_bit, sel_bit}
    logic [10:0] obs_a, obs_b, obs;
    logic [2:0]  obs_st;
    assign obs_a = {bus_a.trap, bus_a.ir_write, bus_a.pc_write, bus_a.sel_bit_PC, bus_a.write_mux_sel,
                    bus_a.reg_write_en, bus_a.mem_write_en, bus_a.mem_read, bus_a.mux1_load_bit, bus_a.sel_bit};
    assign obs_b = {bus_b.trap, bus_b.ir_write, bus_b.pc_write, bus_b.sel_bit_PC, bus_b.write_mux_sel,
                    bus_b.reg_write_en, bus_b.mem_write_en, bus_b.mem_read, bus_b.mux1_load_bit, bus_b.sel_bit};
    assign obs    = (sel == 0) ? obs_a : obs_b;
    assign obs_st = (sel == 0) ? bus_a.state : bus_b.state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input bit ext);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) return C_ILL;
                if (f3 >= 3'd4 && !ext) return C_ILL;
                return C_B;
            end
            default: return C_ILL;
        endcase
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input logic z, input logic l, input logic u);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return u;
            3'd7: return !u;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] ph_state(input int ph);
        case (ph)
            P_F: return 3'd0;
            P_D: return 3'd1;
            P_E: return 3'd2;
            P_MW, P_MD: return 3'd3;
            P_W: return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [10:0] exp_vec(input int ph, input int cls, input logic [2:0] f3,
                                            input logic z, input logic l, input logic u);
        logic tr, ir, pcw, wms, rw, mw, mr, mx, sb;
        logic [1:0] pcs;
        {tr, ir, pcw, wms, rw, mw, mr, mx, sb} = '0;
        pcs = 2'b00;
        case (ph)
            P_F: ir = 1'b1;
            P_E: begin
                case (cls)
                    C_I: sb = 1'b1;
                    C_LW, C_SW: begin sb = 1'b1; mx = 1'b1; end
                    C_B: begin pcw = 1'b1; pcs = br_taken(f3, z, l, u) ? 2'b10 : 2'b00; end
                    C_JAL: begin rw = 1'b1; pcw = 1'b1; pcs = 2'b01; end
                    C_JALR: begin sb = 1'b1; rw = 1'b1; pcw = 1'b1; pcs = 2'b11; end
                    default: ;
                endcase
            end
            P_MW, P_MD: begin
                sb = 1'b1;
                mx = 1'b1;
                mr = (cls == C_LW);
                mw = (cls == C_SW);
                if (ph == P_MD && cls == C_SW) pcw = 1'b1;
            end
            P_W: begin
                rw = 1'b1; wms = 1'b1; pcw = 1'b1;
                if (cls == C_LW) begin mr = 1'b1; mx = 1'b1; end
            end
            P_T: tr = 1'b1;
            default: ;
        endcase
        return {tr, ir, pcw, pcs, wms, rw, mw, mr, mx, sb};
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            opc = 7'($urandom); f3r = 3'($urandom);
            {zf, lf, uf, rdy} = 4'($urandom);
            #1;
            check("reset_outs", 32'(obs), 32'd0);
            if (i == 1) check("reset_state", 32'(obs_st), 32'd0);
        end
    endtask

    // w = MEM cycles without mem_ready; abort_at = phase index where rst_n is pulled low (-1: none)
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int w,
                             input bit force_fl, input logic [2:0] fl, input int abort_at);
        int T, cls, ph[$], pcw_cnt, rw_cnt, rw_exp;
        bit ext, trapped;
        logic [10:0] ev;
        T = (sel == 0) ? 4 : 16;
        ext = (sel == 0);
        cls = classify(op, f3, ext);
        trapped = 1'b0;
        pcw_cnt = 0;
        rw_cnt = 0;
        ph.push_back(P_F);
        ph.push_back(P_D);
        if (cls == C_ILL) begin
            trapped = 1'b1;
        end else begin
            ph.push_back(P_E);
            if (cls == C_R || cls == C_I) ph.push_back(P_W);
            if (cls == C_LW || cls == C_SW) begin
                if (w >= T) begin
                    for (int k = 0; k < T; k++) ph.push_back(P_MW);
                    trapped = 1'b1;
                end else begin
                    for (int k = 0; k < w; k++) ph.push_back(P_MW);
                    ph.push_back(P_MD);
                    if (cls == C_LW) ph.push_back(P_W);
                end
            end
        end
        if (trapped) for (int k = 0; k < 3; k++) ph.push_back(P_T);

        for (int i = 0; i < ph.size(); i++) begin
            @(negedge clk);
            rst_n = (i == abort_at) ? 1'b0 : 1'b1;
            opc = op;
            f3r = f3;
            if (ph[i] == P_MW) rdy = 1'b0;
            else if (ph[i] == P_MD) rdy = 1'b1;
            else rdy = 1'($urandom);
            if (force_fl && ph[i] == P_E) {zf, lf, uf} = fl;
            else {zf, lf, uf} = 3'($urandom);
            #1;
            ev = (i == abort_at) ? 11'd0 : exp_vec(ph[i], cls, f3, zf, lf, uf);
            check($sformatf("state op=%02h f3=%0d cyc%0d", op, f3, i), 32'(obs_st), 32'(ph_state(ph[i])));
            check($sformatf("outs op=%02h f3=%0d cyc%0d", op, f3, i), 32'(obs), 32'(ev));
            pcw_cnt += int'(obs[8]);
            rw_cnt += int'(obs[4]);
            if (i == abort_at) break;
        end

        if (abort_at >= 0 || trapped) begin
            do_reset();
        end else begin
            rw_exp = (cls == C_B || cls == C_SW) ? 0 : 1;
            check($sformatf("pc_write pulses op=%02h", op), 32'(pcw_cnt), 32'd1);
            check($sformatf("reg_write pulses op=%02h", op), 32'(rw_cnt), 32'(rw_exp));
        end
    endtask

    initial begin
        logic [6:0] optab [8];
        logic [6:0] illtab [4];
        optab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111};
        illtab = '{7'h7F, 7'h00, 7'b0110111, 7'b0001111};

        for (int s = 0; s < 2; s++) begin
            sel = s;
            do_reset();
            if (s == 0) begin
                run_instr(7'b0110011, 3'd0, 0, 1'b0, 3'b000, -1);   // add
                run_instr(7'b0000011, 3'd2, 3, 1'b0, 3'b000, -1);   // lw, 3 waits
                run_instr(7'b1100011, 3'd0, 0, 1'b1, 3'b100, -1);   // beq, zero
                run_instr(7'b1100011, 3'd1, 0, 1'b1, 3'b100, -1);   // bne, zero
                run_instr(7'b1100011, 3'd4, 0, 1'b1, 3'b010, -1);   // blt, lt
                run_instr(7'b1100011, 3'd7, 0, 1'b1, 3'b001, -1);   // bgeu, ltu
                run_instr(7'b1100111, 3'd0, 0, 1'b0, 3'b000, -1);   // jalr
                run_instr(7'b0100011, 3'd2, 3, 1'b0, 3'b000, -1);   // sw, last chance ready
                run_instr(7'b0100011, 3'd2, 1000, 1'b0, 3'b000, -1); // sw timeout
                run_instr(7'h7F, 3'd0, 0, 1'b0, 3'b000, -1);        // illegal opcode
                run_instr(7'b1100011, 3'd2, 0, 1'b0, 3'b000, -1);   // illegal branch func3
                run_instr(7'b0000011, 3'd2, 3, 1'b0, 3'b000, 4);    // reset in 2nd MEM cycle
            end else begin
                run_instr(7'b1100011, 3'd5, 0, 1'b0, 3'b000, -1);   // bge, ext disabled
                run_instr(7'b1100011, 3'd0, 0, 1'b1, 3'b100, -1);   // beq still legal
                run_instr(7'b0000011, 3'd2, 15, 1'b0, 3'b000, -1);  // lw, ready at last cycle
                run_instr(7'b0100011, 3'd2, 16, 1'b0, 3'b000, -1);  // sw timeout
            end
            for (int n = 0; n < 60; n++) begin
                int idx;
                logic [6:0] op;
                idx = $urandom_range(0, 7);
                op = (idx == 7) ? illtab[$urandom_range(0, 3)] : optab[idx];
                run_instr(op, 3'($urandom), $urandom_range(0, (s == 0) ? 5 : 17),
                          1'b0, 3'b000, ($urandom_range(0, 19) == 0) ? 3 : -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
